// File: rtl/bitscan_iter_if.sv
// Handshake bundle for bitscan_iter: word input stream and per-set-bit output beat stream.
interface bitscan_iter_if #(
  parameter int ORDER = 3
);
  localparam int W = 2 ** ORDER;

  logic [W-1:0]   in_data;
  logic           in_valid;
  logic           in_ready;
  logic [ORDER-1:0] out_index;
  logic           out_none;
  logic           out_last;
  logic [ORDER:0] out_count;
  logic           out_valid;
  logic           out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_index, out_none, out_last, out_count, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_index, out_none, out_last, out_count, out_valid
  );
endinterface

// File: rtl/bitscan_iter.sv
// Iterates over the set bits of an accepted word, one beat per set bit (lowest or highest first).
// state | meaning
// IDLE  | no word held, ready for a new word
// SCAN  | word held, a beat is presented on out_*
module bitscan_iter #(
  parameter int ORDER     = 3,
  parameter int MSB_FIRST = 0
) (
  input logic           clock,
  input logic           reset,
  bitscan_iter_if.slave bus
);
  localparam int W = 2 ** ORDER;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state, state_nxt;
  logic [W-1:0]     rem;
  logic [ORDER:0]   count;
  logic             none;
  logic [ORDER-1:0] idx;
  logic [W-1:0]     rem_dec;
  logic             last;
  logic             valid;
  logic             accept;
  logic             beat;
  logic             ready;

  function automatic logic [ORDER:0] popcount(input logic [W-1:0] v);
    logic [ORDER:0] c;
    c = '0;
    for (int i = 0; i < W; i++) c = c + {{ORDER{1'b0}}, v[i]};
    return c;
  endfunction

  // Later matches overwrite earlier ones, so loop direction picks the scan order.
  always_comb begin
    idx = '0;
    if (MSB_FIRST != 0) begin
      for (int i = 0; i < W; i++)
        if (rem[i]) idx = i[ORDER-1:0];
    end else begin
      for (int i = W - 1; i >= 0; i--)
        if (rem[i]) idx = i[ORDER-1:0];
    end
  end

  assign rem_dec = rem - {{(W-1){1'b0}}, 1'b1};
  assign last    = ((rem & rem_dec) == '0);
  assign valid   = (state == SCAN);
  assign beat    = valid & bus.out_ready;
  assign ready   = (state == IDLE) | (beat & last);
  assign accept  = bus.in_valid & ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = SCAN;
      SCAN: if (beat && last) state_nxt = accept ? SCAN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rem   <= '0;
      count <= '0;
      none  <= 1'b0;
    end else if (accept) begin
      rem   <= bus.in_data;
      count <= popcount(bus.in_data);
      none  <= (bus.in_data == '0);
    end else if (beat) begin
      rem   <= rem & ~({{(W-1){1'b0}}, 1'b1} << idx);
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = valid;
  assign bus.out_index = idx;
  assign bus.out_last  = last;
  assign bus.out_count = count;
  assign bus.out_none  = none;
endmodule
